// File: rtl/instr_fetch_queue.sv
// Dual-issue fetch queue: fetches aligned instruction pairs and presents the two oldest to decode.
// Optional IFQ_BYPASS_EN: when the queue is empty, the fetched words drive the slots directly.
module instr_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata0,
    input  logic [31:0] imem_rdata1,
    input  logic [1:0]  issue_cnt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        slot0_valid,
    output logic [31:0] slot0_instr,
    output logic [31:0] slot0_pc,
    output logic        slot1_valid,
    output logic [31:0] slot1_instr,
    output logic [31:0] slot1_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [AW-1:0] head, tail, head1, tail1;
    logic [CW-1:0] count, free, issue_w, push_n, pop_n, skip_n, wr_n;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   w0_pc, w0_instr, w1_pc, w1_instr;
    logic          bypass;
    logic          unused_bits;

    assign unused_bits = &{1'b0, fetch_pc[1:0]};

    assign head1     = head + AW'(1);
    assign tail1     = tail + AW'(1);
    assign free      = CW'(DEPTH) - count;
    assign issue_w   = CW'(issue_cnt);
    assign imem_addr = {fetch_pc[31:3], 3'b000};
    assign imem_req  = rst_n & ~redirect & (free >= CW'(2));

    // w0 is always the first word to enter the queue; an odd fetch PC drops rdata0
    always_comb begin
        w0_pc    = imem_addr;
        w0_instr = imem_rdata0;
        w1_pc    = imem_addr + 32'd4;
        w1_instr = imem_rdata1;
        push_n   = '0;
        if (imem_req) begin
            if (fetch_pc[2]) begin
                w0_pc    = w1_pc;
                w0_instr = w1_instr;
                push_n   = CW'(1);
            end else begin
                push_n   = CW'(2);
            end
        end
    end

`ifdef IFQ_BYPASS_EN
    assign bypass = (count == '0) && imem_req;
`else
    assign bypass = 1'b0;
`endif

    // Issue beyond the valid count is clamped; in bypass, issued words never land in the queue
    assign pop_n  = (issue_w < count) ? issue_w : count;
    assign skip_n = bypass ? ((issue_w < push_n) ? issue_w : push_n) : '0;
    assign wr_n   = push_n - skip_n;

    always_ff @(posedge clk) begin
        if (wr_n == CW'(2)) begin
            q_pc[tail]     <= w0_pc;
            q_instr[tail]  <= w0_instr;
            q_pc[tail1]    <= w1_pc;
            q_instr[tail1] <= w1_instr;
        end else if (wr_n == CW'(1)) begin
            q_pc[tail]     <= (skip_n == '0) ? w0_pc : w1_pc;
            q_instr[tail]  <= (skip_n == '0) ? w0_instr : w1_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (imem_req)
                fetch_pc <= imem_addr + 32'd8;
            head  <= head + pop_n[AW-1:0];
            tail  <= tail + wr_n[AW-1:0];
            count <= count + wr_n - pop_n;
        end
    end

    always_comb begin
        slot0_valid = 1'b0;
        slot0_instr = '0;
        slot0_pc    = '0;
        slot1_valid = 1'b0;
        slot1_instr = '0;
        slot1_pc    = '0;
        if (bypass) begin
            slot0_valid = 1'b1;
            slot0_instr = w0_instr;
            slot0_pc    = w0_pc;
            if (push_n == CW'(2)) begin
                slot1_valid = 1'b1;
                slot1_instr = w1_instr;
                slot1_pc    = w1_pc;
            end
        end else begin
            if (count >= CW'(1)) begin
                slot0_valid = 1'b1;
                slot0_instr = q_instr[head];
                slot0_pc    = q_pc[head];
            end
            if (count >= CW'(2)) begin
                slot1_valid = 1'b1;
                slot1_instr = q_instr[head1];
                slot1_pc    = q_pc[head1];
            end
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Dual-issue fetch stage sitting directly upstream of instruction decode and the control unit.
- Fetches an aligned pair of 32-bit words per cycle from instruction memory and buffers them with their PCs in a circular queue.
- Presents the two oldest instructions (slot0 = older, slot1 = younger) to decode, which supplies opcode/funct to the control unit.
- Handles decode's issue count (0/1/2) and branch/jump redirect flushes.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- RESET_PC, 32'h0000_0000, fetch PC after reset; word aligned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch enable to instruction memory
- imem_addr  out  32  pair-aligned fetch address, {fetch_pc[31:3],3'b000}
- imem_rdata0  in  32  word at imem_addr, combinational same cycle
- imem_rdata1  in  32  word at imem_addr+4, combinational same cycle
- issue_cnt  in  2  instructions consumed by decode this cycle (0, 1 or 2)
- redirect  in  1  flush queue and restart fetch (taken branch, J, JAL, JR)
- redirect_pc  in  32  new fetch PC, word aligned
- slot0_valid  out  1  slot0 holds an instruction
- slot0_instr  out  32  oldest instruction
- slot0_pc  out  32  PC of slot0
- slot1_valid  out  1  slot1 holds an instruction
- slot1_instr  out  32  second-oldest instruction
- slot1_pc  out  32  PC of slot1

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; head=tail=0; count=0.
  - All slot outputs 0; imem_req=0.
- Entry = {pc[31:0], instr[31:0]}; count width clog2(DEPTH)+1; free = DEPTH-count.
- imem_req = rst_n & ~redirect & (free >= 2).
- Fetch (when imem_req=1):
  - fetch_pc[2]=0: push rdata0 (pc=imem_addr), then rdata1 (pc=imem_addr+4).
  - fetch_pc[2]=1: push only rdata1 (pc=imem_addr+4); rdata0 is discarded.
  - Next fetch_pc = imem_addr+8 (32-bit wrap, no trap).
- Pop: pop_n = min(issue_cnt, count), so an issue_cnt above the valid count is clamped, never underflows.
- Push and pop occur in the same cycle: count_next = count + push_n - pop_n; head and tail wrap modulo DEPTH.
- No overflow is possible, because a push requires free >= 2 before the pop.
- Slot outputs are pure functions of the registered queue state:
  - slot0 = entry[head], valid when count >= 1.
  - slot1 = entry[head+1], valid when count >= 2.
  - Invalid slots drive instr=0 and pc=0.
- Redirect has priority over every other event in the same cycle:
  - Queue cleared (count=0, head=tail=0); the pop and the push of that cycle are discarded; fetch_pc=redirect_pc.
  - Latency: redirect asserted in cycle N; fetch at redirect_pc in N+1; slot0_valid in N+2.
- Back-to-back redirects: the last one wins; the queue stays empty.
- Decode may rely on slot0_pc+4 == slot1_pc only when no redirect boundary lies between the two entries. The queue never reorders entries.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined, when count==0 and imem_req=1:
  - Slots are driven combinationally from the imem words: slot0 = first pushable word, slot1 = rdata1 when the pair is aligned.
  - Only words not consumed by issue_cnt are written into the queue.
  - Redirect-to-valid latency drops to 1 cycle (slot0_valid in N+1).
- Undefined: slots are register-derived only; 2-cycle redirect latency.

Test Plan:
- Reset, RESET_PC=0, issue_cnt=0 -> cycle 1: imem_req=1, imem_addr=0. Cycle 2: slot0_pc=0, slot1_pc=4, both valid, slot instrs match imem words.
- DEPTH=8, issue_cnt held 0 for 6 cycles -> count=8 after 4 fetches; imem_req=0; fetch_pc holds 0x20; slots unchanged.
- issue_cnt=1 every cycle from a full queue -> slot0_pc advances by 4 each cycle; fetch resumes once free>=2.
- redirect=1, redirect_pc=0x104 -> next cycle imem_addr=0x100 and only pc 0x104 is pushed. The following fetch is at 0x108; slot1_pc=0x108 once that pair lands.
- redirect=1 with issue_cnt=2 and count=6 -> next cycle count=0, both slots invalid, slot outputs zero, no pop side effects.
- rst_n pulled low mid-stream (not at a clock edge) -> slot valids and imem_req go 0 immediately. After release, fetch restarts at RESET_PC.
